// File: rtl/button_debounce_pkg.sv
// button_debounce_pkg
//   Shared defaults for the button debouncer and a configuration check used at
//   elaboration time.
//   N_BUTTONS_DEF       : number of button channels
//   DEBOUNCE_CYCLES_DEF : stable cycles needed before a level change is accepted
//   CNT_WIDTH_DEF       : per-channel stability counter width
package button_debounce_pkg;

  localparam int N_BUTTONS_DEF       = 8;
  localparam int DEBOUNCE_CYCLES_DEF = 10000;
  localparam int CNT_WIDTH_DEF       = 16;

  // True when the terminal count (cycles-1) is representable in 'width' bits
  // and the threshold is at least one cycle.
  function automatic bit cnt_fits(input longint cycles, input int width);
    return (cycles >= 1) && ((cycles - 1) < (longint'(1) << width));
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel
//   One button channel: 2-flop synchronizer, stability counter, debounced level
//   and registered one-cycle rise/fall pulses.
//   clk     : clock
//   rst_n   : asynchronous active-low reset
//   raw     : raw pad input (1 = pressed)
//   level   : debounced level
//   rise    : high for the cycle in which level first shows 1
//   fall    : high for the cycle in which level first shows 0
module debounce_channel
  import button_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  logic [1:0]           sync;
  logic                 s;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 level_next;
  logic                 rise_next;
  logic                 fall_next;

  assign s = sync[1];

  // The counter only advances while the synchronized input disagrees with
  // the accepted level; any agreement (a glitch back) restarts it from 0.
  // It is cleared on acceptance, so it can never exceed LAST and never wraps.
  always_comb begin
    cnt_next   = '0;
    level_next = level;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    if (s != level) begin
      if (cnt == LAST) begin
        level_next = s;
        rise_next  = s;
        fall_next  = ~s;
      end else begin
        cnt_next = cnt + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      cnt   <= cnt_next;
      level <= level_next;
      rise  <= rise_next;
      fall  <= fall_next;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// button_debounce
//   N independent debounced button channels with sticky press flags and a
//   maskable level interrupt.
//   wb_clk_i   : clock (single domain)
//   wb_rst_n_i : asynchronous active-low reset
//   btn_i      : raw pad inputs, 1 = pressed
//   btn_o      : debounced levels
//   rise_o     : one-cycle press pulse per channel
//   fall_o     : one-cycle release pulse per channel
//   clr_i      : per-bit clear of pending_o
//   mask_i     : per-bit interrupt enable
//   pending_o  : sticky press-event flags
//   irq_o      : registered OR of enabled pending flags
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int N_BUTTONS       = N_BUTTONS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  input  logic [N_BUTTONS-1:0] btn_i,
  output logic [N_BUTTONS-1:0] btn_o,
  output logic [N_BUTTONS-1:0] rise_o,
  output logic [N_BUTTONS-1:0] fall_o,
  input  logic [N_BUTTONS-1:0] clr_i,
  input  logic [N_BUTTONS-1:0] mask_i,
  output logic [N_BUTTONS-1:0] pending_o,
  output logic                 irq_o
);

  if (!cnt_fits(DEBOUNCE_CYCLES, CNT_WIDTH)) begin : g_bad_cfg
    $error("button_debounce: DEBOUNCE_CYCLES-1 must fit in CNT_WIDTH bits");
  end

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_WIDTH       (CNT_WIDTH)
    ) u_ch (
      .clk   (wb_clk_i),
      .rst_n (wb_rst_n_i),
      .raw   (btn_i[i]),
      .level (btn_o[i]),
      .rise  (rise_o[i]),
      .fall  (fall_o[i])
    );
  end

  // Pending is set from the registered rise pulse, so a clear issued in the
  // rise_o cycle collides with the set and the set wins.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      pending_o <= '0;
      irq_o     <= 1'b0;
    end else begin
      pending_o <= (pending_o & ~clr_i) | rise_o;
      irq_o     <= |(pending_o & mask_i);
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce
//   Randomized and directed stimulus for button_debounce (DEBOUNCE_CYCLES=4).
//   Expected outputs come from a sliding-window reference model: a level flips
//   once the last DEBOUNCE_CYCLES synchronized samples all disagree with it.
module tb_button_debounce;

  localparam int NB = 8;
  localparam int DC = 4;
  localparam int CW = 3;
  localparam int W  = 4 * NB + 1;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NB-1:0] btn_i  = '0;
  logic [NB-1:0] clr_i  = '0;
  logic [NB-1:0] mask_i = '0;
  logic [NB-1:0] btn_o;
  logic [NB-1:0] rise_o;
  logic [NB-1:0] fall_o;
  logic [NB-1:0] pending_o;
  logic          irq_o;

  button_debounce #(
    .N_BUTTONS       (NB),
    .DEBOUNCE_CYCLES (DC),
    .CNT_WIDTH       (CW)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .btn_i      (btn_i),
    .btn_o      (btn_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .clr_i      (clr_i),
    .mask_i     (mask_i),
    .pending_o  (pending_o),
    .irq_o      (irq_o)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [NB-1:0] h_q[$];
  logic [NB-1:0] m_lvl, m_rise, m_fall, m_pend;
  logic          m_irq;

  task automatic model_reset();
    m_lvl  = '0;
    m_rise = '0;
    m_fall = '0;
    m_pend = '0;
    m_irq  = 1'b0;
    h_q.delete();
    for (int k = 0; k < DC + 2; k++) h_q.push_back('0);
  endtask

  // Advance the model across one rising edge with the currently driven inputs.
  task automatic model_edge();
    logic [NB-1:0] flip;
    logic [NB-1:0] n_pend;
    logic          n_irq;
    if (!rst_n) begin
      model_reset();
    end else begin
      n_pend = (m_pend & ~clr_i) | m_rise;
      n_irq  = |(m_pend & mask_i);
      h_q.push_back(btn_i);
      void'(h_q.pop_front());
      // h_q[0..DC-1] are the samples the synchronizer delivers at this edge
      // and the DC-1 edges before it.
      flip = '1;
      for (int k = 0; k < DC; k++) flip &= h_q[k] ^ m_lvl;
      m_rise = flip & ~m_lvl;
      m_fall = flip & m_lvl;
      m_lvl  = m_lvl ^ flip;
      m_pend = n_pend;
      m_irq  = n_irq;
    end
  endtask

  function automatic logic [W-1:0] dut_vec();
    return {btn_o, rise_o, fall_o, pending_o, irq_o};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // driver: called at a falling edge; drives inputs, records the expected
  // response for the coming rising edge, returns at the next falling edge
  task automatic step(input logic [NB-1:0] b, input logic [NB-1:0] c, input logic [NB-1:0] m);
    btn_i  = b;
    clr_i  = c;
    mask_i = m;
    model_edge();
    exp_q.push_back({m_lvl, m_rise, m_fall, m_pend, m_irq});
    @(negedge clk);
  endtask

  task automatic steps(input int n, input logic [NB-1:0] b, input logic [NB-1:0] c,
                       input logic [NB-1:0] m);
    for (int k = 0; k < n; k++) step(b, c, m);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("reset_async", dut_vec(), '0);
    for (int k = 0; k < cycles; k++) step(btn_i, '0, mask_i);
    rst_n = 1'b1;
  endtask

  // monitor: outputs are presented every cycle; compare after each rising edge
  always begin
    logic [W-1:0] exp_v;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      n_checks++;
      if (dut_vec() !== exp_v) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t got=%h expected=%h", $time, dut_vec(), exp_v);
      end
    end
  end

  task automatic report();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog t=%0t got=running expected=finished", $time);
    report();
    $finish;
  end

  // stimulus
  initial begin
    logic [NB-1:0] b;
    logic [NB-1:0] m;
    logic [NB-1:0] fm;
    model_reset();
    @(negedge clk);
    do_reset(2);

    // clean press on channel 0
    steps(5, 8'h01, 8'h00, 8'h01);
    chk("press_wait", W'(btn_o), W'(8'h00));
    step(8'h01, 8'h00, 8'h01);
    chk("press_level", W'(btn_o), W'(8'h01));
    chk("press_rise", W'(rise_o), W'(8'h01));
    chk("press_pend_early", W'(pending_o), W'(8'h00));
    step(8'h01, 8'h00, 8'h01);
    chk("press_pend", W'(pending_o), W'(8'h01));
    chk("press_rise_once", W'(rise_o), W'(8'h00));
    step(8'h01, 8'h00, 8'h01);
    chk("press_irq", W'(irq_o), W'(1'b1));

    // bounce on channel 3: 1,0,1 at 2-cycle intervals, then held
    steps(2, 8'h09, 8'h00, 8'h01);
    steps(2, 8'h01, 8'h00, 8'h01);
    steps(5, 8'h09, 8'h00, 8'h01);
    chk("bounce_wait", W'(btn_o), W'(8'h01));
    step(8'h09, 8'h00, 8'h01);
    chk("bounce_level", W'(btn_o), W'(8'h09));
    chk("bounce_rise", W'(rise_o), W'(8'h08));

    // release channel 0, then clear its pending flag
    steps(5, 8'h08, 8'h00, 8'h01);
    chk("release_wait", W'(btn_o), W'(8'h09));
    step(8'h08, 8'h00, 8'h01);
    chk("release_fall", W'(fall_o), W'(8'h01));
    chk("release_pend", W'(pending_o), W'(8'h09));
    step(8'h08, 8'h01, 8'h01);
    chk("clear_pend", W'(pending_o), W'(8'h08));
    step(8'h08, 8'h00, 8'h01);
    chk("clear_irq", W'(irq_o), W'(1'b0));

    // clear collides with the rise_o cycle of channel 5
    steps(6, 8'h28, 8'h00, 8'h01);
    chk("collide_rise", W'(rise_o), W'(8'h20));
    step(8'h28, 8'h20, 8'h01);
    chk("collide_pend", W'(pending_o), W'(8'h28));
    step(8'h28, 8'h20, 8'h01);
    chk("collide_later_clear", W'(pending_o), W'(8'h08));

    // release everything, then press all eight together with irq masked
    steps(8, 8'h00, 8'hFF, 8'h01);
    chk("idle_level", W'(btn_o), W'(8'h00));
    chk("idle_pend", W'(pending_o), W'(8'h00));
    steps(6, 8'hFF, 8'h00, 8'h00);
    chk("all_rise", W'(rise_o), W'(8'hFF));
    chk("all_level", W'(btn_o), W'(8'hFF));
    steps(3, 8'hFF, 8'h00, 8'h00);
    chk("all_pend", W'(pending_o), W'(8'hFF));
    chk("all_irq_masked", W'(irq_o), W'(1'b0));

    // reset in the middle of a debounce with the button held
    steps(8, 8'h00, 8'h00, 8'hFF);
    chk("pre_reset_irq", W'(irq_o), W'(1'b1));
    steps(4, 8'h01, 8'h00, 8'hFF);
    do_reset(2);
    steps(5, 8'h01, 8'h00, 8'hFF);
    chk("post_reset_wait", W'(btn_o), W'(8'h00));
    step(8'h01, 8'h00, 8'hFF);
    chk("post_reset_rise", W'(rise_o), W'(8'h01));
    step(8'h01, 8'h00, 8'hFF);
    chk("post_reset_pend", W'(pending_o), W'(8'h01));
    step(8'h01, 8'h00, 8'hFF);
    chk("post_reset_irq", W'(irq_o), W'(1'b1));

    // randomized traffic
    b = btn_i;
    m = 8'($urandom());
    for (int n = 0; n < 500; n++) begin
      fm = '0;
      for (int k = 0; k < NB; k++) fm[k] = ($urandom_range(0, 9) == 0);
      b = b ^ fm;
      if ($urandom_range(0, 49) == 0) m = 8'($urandom());
      if ($urandom_range(0, 199) == 0) do_reset(int'($urandom_range(1, 3)));
      step(b, 8'($urandom()) & 8'($urandom()) & 8'($urandom()), m);
    end
    steps(2, b, 8'h00, m);

    chk("queue_drained", W'(exp_q.size()), W'(0));
    report();
    $finish;
  end

endmodule
